// File: rtl/halt_result_checker_pkg.sv
// Shared definitions for the halt/result checker: FSM states, the default
// halt instruction word and a width helper used for address ports.
package halt_result_checker_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_CHECK_MEM = 3'd2,
        ST_CHECK_REG = 3'd3,
        ST_DONE      = 3'd4,
        ST_TIMEOUT   = 3'd5
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Ceiling log2, never less than 1 so that degenerate sizes still give a legal vector
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if (int'(32'd1 << r) < value) begin
                result = r + 1;
            end else begin
                result = result;
            end
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/halt_result_checker_down_counter.sv
// Loadable down-counter with a zero flag. Counts stop at zero; a load
// takes priority over a decrement. RST_VAL is the value held after reset.
module chk_down_counter #(
    parameter int            W       = 8,
    parameter logic [W-1:0]  RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(32'd1);

    logic [W-1:0] count_r;

    // Count register: load, else decrement while non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= RST_VAL;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/halt_result_checker.sv
// End-of-program monitor: waits for the halt instruction, lets the pipeline
// drain, then walks data memory and the register file comparing each word
// against the expected table, reporting every mismatch and a final verdict.
module halt_result_checker
    import halt_result_checker_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] HALT_WORD      = DATA_W'(HALT_WORD_DEFAULT),
    parameter int                DRAIN_CYCLES   = 5,
    parameter int                MEM_WORDS      = 32,
    parameter int                REG_WORDS      = 32,
    parameter int                TIMEOUT_CYCLES = 200,
    parameter int                ERR_W          = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [DATA_W-1:0]                              instr_i,
    output logic [clog2_min1(MEM_WORDS)-1:0]               mem_addr_o,
    input  logic [DATA_W-1:0]                              mem_data_i,
    output logic [4:0]                                     reg_addr_o,
    input  logic [DATA_W-1:0]                              reg_data_i,
    output logic [clog2_min1(MEM_WORDS+REG_WORDS)-1:0]     exp_addr_o,
    input  logic [DATA_W-1:0]                              exp_data_i,
    output logic                                           err_valid_o,
    output logic                                           err_is_reg_o,
    output logic [7:0]                                     err_index_o,
    output logic [DATA_W-1:0]                              err_exp_o,
    output logic [DATA_W-1:0]                              err_got_o,
    output logic [ERR_W-1:0]                               error_count_o,
    output logic                                           done_o,
    output logic                                           pass_o,
    output logic                                           timeout_o
);

    localparam int MEM_AW = clog2_min1(MEM_WORDS);
    localparam int EXP_AW = clog2_min1(MEM_WORDS + REG_WORDS);
    localparam int DRN_W  = clog2_min1(DRAIN_CYCLES);
    localparam int TMO_W  = clog2_min1(TIMEOUT_CYCLES);

    localparam logic [MEM_AW-1:0] MEM_ONE   = MEM_AW'(32'd1);
    localparam logic [EXP_AW-1:0] EXP_ONE   = EXP_AW'(32'd1);
    localparam logic [EXP_AW-1:0] EXP_REG0  = EXP_AW'(MEM_WORDS);
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(32'd1);
    localparam logic [7:0]        MEM_LAST  = 8'(MEM_WORDS - 1);
    localparam logic [7:0]        REG_LAST  = 8'(REG_WORDS - 1);
    // The drain counter is loaded one short so the first word is compared
    // exactly DRAIN_CYCLES+1 edges after the halt edge.
    localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [TMO_W-1:0]  TMO_RST   = TMO_W'(TIMEOUT_CYCLES - 1);

    // Phase entered once draining is over; skips empty phases.
    localparam state_e FIRST_CHECK = (MEM_WORDS > 0) ? ST_CHECK_MEM :
                                     (REG_WORDS > 0) ? ST_CHECK_REG : ST_DONE;

    state_e              state_r;
    logic [7:0]          idx_r;
    logic [MEM_AW-1:0]   mem_addr_r;
    logic [4:0]          reg_addr_r;
    logic [EXP_AW-1:0]   exp_addr_r;
    logic                err_valid_r;
    logic                err_is_reg_r;
    logic [7:0]          err_index_r;
    logic [DATA_W-1:0]   err_exp_r;
    logic [DATA_W-1:0]   err_got_r;
    logic [ERR_W-1:0]    error_count_r;
    logic                done_r;
    logic                pass_r;
    logic                timeout_r;

    logic                halt_s;
    logic                mism_s;
    logic                is_reg_s;
    logic [DATA_W-1:0]   got_s;
    logic                err_sat_s;
    logic                pass_next_s;
    logic                drain_load_s;
    logic                drain_dec_s;
    logic                drain_zero_s;
    logic                tmo_dec_s;
    logic                tmo_zero_s;

    assign halt_s       = (instr_i == HALT_WORD);
    assign err_sat_s    = &error_count_r;
    assign pass_next_s  = (error_count_r == {ERR_W{1'b0}}) && !mism_s;
    assign drain_load_s = (state_r == ST_RUN) && halt_s;
    assign drain_dec_s  = (state_r == ST_DRAIN);
    assign tmo_dec_s    = (state_r == ST_RUN);

    // Select the word under test for the active phase and flag a mismatch
    always_comb begin
        mism_s   = 1'b0;
        is_reg_s = 1'b0;
        got_s    = mem_data_i;
        if (state_r == ST_CHECK_MEM) begin
            mism_s = (mem_data_i != exp_data_i);
        end else if (state_r == ST_CHECK_REG) begin
            is_reg_s = 1'b1;
            got_s    = reg_data_i;
            mism_s   = (reg_data_i != exp_data_i);
        end else begin
            mism_s   = 1'b0;
        end
    end

    chk_down_counter #(
        .W       (DRN_W),
        .RST_VAL ({DRN_W{1'b0}})
    ) u_drain_cnt (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (drain_load_s),
        .load_val (DRN_LOAD),
        .dec      (drain_dec_s),
        .zero     (drain_zero_s)
    );

    chk_down_counter #(
        .W       (TMO_W),
        .RST_VAL (TMO_RST)
    ) u_timeout_cnt (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (1'b0),
        .load_val (TMO_RST),
        .dec      (tmo_dec_s),
        .zero     (tmo_zero_s)
    );

    // Checker FSM: sequencing, address generation, mismatch reporting and verdict
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r       <= ST_RUN;
            idx_r         <= 8'd0;
            mem_addr_r    <= {MEM_AW{1'b0}};
            reg_addr_r    <= 5'd0;
            exp_addr_r    <= {EXP_AW{1'b0}};
            err_valid_r   <= 1'b0;
            err_is_reg_r  <= 1'b0;
            err_index_r   <= 8'd0;
            err_exp_r     <= {DATA_W{1'b0}};
            err_got_r     <= {DATA_W{1'b0}};
            error_count_r <= {ERR_W{1'b0}};
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            err_valid_r <= 1'b0;
            if (mism_s) begin
                err_valid_r  <= 1'b1;
                err_is_reg_r <= is_reg_s;
                err_index_r  <= idx_r;
                err_exp_r    <= exp_data_i;
                err_got_r    <= got_s;
                if (!err_sat_s) begin
                    error_count_r <= error_count_r + ERR_ONE;
                end
            end

            case (state_r)
                ST_RUN: begin
                    if (halt_s) begin
                        if (DRAIN_CYCLES > 0) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= FIRST_CHECK;
                            if (FIRST_CHECK == ST_DONE) begin
                                done_r <= 1'b1;
                                pass_r <= pass_next_s;
                            end
                        end
                    end else if (tmo_zero_s) begin
                        state_r   <= ST_TIMEOUT;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_zero_s) begin
                        state_r <= FIRST_CHECK;
                        if (FIRST_CHECK == ST_DONE) begin
                            done_r <= 1'b1;
                            pass_r <= pass_next_s;
                        end
                    end
                end
                ST_CHECK_MEM: begin
                    if (idx_r == MEM_LAST) begin
                        idx_r      <= 8'd0;
                        mem_addr_r <= {MEM_AW{1'b0}};
                        if (REG_WORDS > 0) begin
                            state_r    <= ST_CHECK_REG;
                            reg_addr_r <= 5'd0;
                            exp_addr_r <= EXP_REG0;
                        end else begin
                            state_r    <= ST_DONE;
                            exp_addr_r <= {EXP_AW{1'b0}};
                            done_r     <= 1'b1;
                            pass_r     <= pass_next_s;
                        end
                    end else begin
                        idx_r      <= idx_r + 8'd1;
                        mem_addr_r <= mem_addr_r + MEM_ONE;
                        exp_addr_r <= exp_addr_r + EXP_ONE;
                    end
                end
                ST_CHECK_REG: begin
                    if (idx_r == REG_LAST) begin
                        state_r    <= ST_DONE;
                        idx_r      <= 8'd0;
                        reg_addr_r <= 5'd0;
                        exp_addr_r <= {EXP_AW{1'b0}};
                        done_r     <= 1'b1;
                        pass_r     <= pass_next_s;
                    end else begin
                        idx_r      <= idx_r + 8'd1;
                        reg_addr_r <= reg_addr_r + 5'd1;
                        exp_addr_r <= exp_addr_r + EXP_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_TIMEOUT: begin
                    state_r <= ST_TIMEOUT;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign mem_addr_o    = mem_addr_r;
    assign reg_addr_o    = reg_addr_r;
    assign exp_addr_o    = exp_addr_r;
    assign err_valid_o   = err_valid_r;
    assign err_is_reg_o  = err_is_reg_r;
    assign err_index_o   = err_index_r;
    assign err_exp_o     = err_exp_r;
    assign err_got_o     = err_got_r;
    assign error_count_o = error_count_r;
    assign done_o        = done_r;
    assign pass_o        = pass_r;
    assign timeout_o     = timeout_r;

endmodule
